// File: rtl/piece_sequencer.sv
// piece_sequencer: 7-bag piece generator with a 4-entry queue (head + 3 preview)
// and a single hold slot.
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   flush            clear queue, bag and hold for a new game (LFSR keeps running)
//   spawn_req        request the next active piece from the queue
//   hold_req         swap the active piece (active_idx) with the hold slot
//   active_idx       piece currently falling, captured on an accepted hold_req
//   spawn_valid      one-cycle pulse, spawn_idx / spawn_from_hold valid
//   spawn_idx        issued piece (0-6, 7 = empty)
//   spawn_from_hold  issued piece came out of the hold slot
//   next_idx         preview {next+2, next+1, next}, 7 = empty entry
//   hold_valid/idx   hold slot occupancy and contents
//   hold_used        a hold has been taken since the last queue-served spawn
//   hold_reject      one-cycle pulse for an ignored hold_req
//   queue_count      number of queue entries (0-4)
//   busy             a request is waiting to be served
module piece_sequencer #(
    parameter logic [15:0] SEED   = 16'hACE1,
    parameter int unsigned QDEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       spawn_req,
    input  logic       hold_req,
    input  logic [2:0] active_idx,
    output logic       spawn_valid,
    output logic [2:0] spawn_idx,
    output logic       spawn_from_hold,
    output logic [8:0] next_idx,
    output logic       hold_valid,
    output logic [2:0] hold_idx,
    output logic       hold_used,
    output logic       hold_reject,
    output logic [2:0] queue_count,
    output logic       busy
);

    localparam logic [2:0] QFULL    = 3'(QDEPTH);
    localparam logic [2:0] EMPTY    = 3'd7;
    localparam logic [6:0] FULL_BAG = 7'h7F;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ISSUE
    } state_t;

    state_t     state;
    logic [15:0] lfsr;
    logic [6:0]  bag_mask;
    logic [2:0]  q [QDEPTH];
    logic [2:0]  cnt;

    // Pending request: hold (vs. plain spawn), swap with an occupied hold slot,
    // and the active piece captured when the hold was accepted.
    logic        pend_hold;
    logic        pend_swap;
    logic [2:0]  pend_active;

    logic [15:0] lfsr_n;
    logic [2:0]  cand;
    logic        draw_ok;
    logic [6:0]  mask_n;
    logic        serve;
    logic        pop;
    logic [2:0]  q_n [QDEPTH];
    logic [2:0]  cnt_n;

    assign next_idx    = {q[3], q[2], q[1]};
    assign queue_count = cnt;

    // Draw candidate, bag bookkeeping and queue next-state.
    always_comb begin
        lfsr_n  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        cand    = lfsr[2:0];
        draw_ok = !flush && (cnt < QFULL) && (cand != EMPTY) && bag_mask[cand];
        mask_n  = bag_mask & ~(7'b1 << cand);
        if (mask_n == 7'h00) begin
            mask_n = FULL_BAG;
        end

        // A swap with the hold slot does not need the queue; everything else
        // waits until the queue is full.
        serve = (state == S_WAIT) && (pend_swap || (cnt == QFULL));
        pop   = serve && !pend_swap && !flush;

        for (int i = 0; i < QDEPTH; i++) begin
            q_n[i] = q[i];
        end
        cnt_n = cnt;
        if (pop) begin
            for (int i = 0; i < QDEPTH - 1; i++) begin
                q_n[i] = q[i + 1];
            end
            q_n[QDEPTH - 1] = EMPTY;
            cnt_n = cnt - 3'd1;
        end
        if (draw_ok) begin
            q_n[cnt_n[1:0]] = cand;
            cnt_n = cnt_n + 3'd1;
        end
    end

    // Request FSM plus all registered state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            lfsr            <= SEED;
            bag_mask        <= FULL_BAG;
            for (int i = 0; i < QDEPTH; i++) begin
                q[i] <= EMPTY;
            end
            cnt             <= 3'd0;
            hold_valid      <= 1'b0;
            hold_idx        <= EMPTY;
            hold_used       <= 1'b0;
            spawn_valid     <= 1'b0;
            spawn_idx       <= EMPTY;
            spawn_from_hold <= 1'b0;
            hold_reject     <= 1'b0;
            busy            <= 1'b0;
            pend_hold       <= 1'b0;
            pend_swap       <= 1'b0;
            pend_active     <= EMPTY;
        end else begin
            lfsr        <= lfsr_n;
            spawn_valid <= 1'b0;
            hold_reject <= 1'b0;

            if (flush) begin
                state      <= S_IDLE;
                bag_mask   <= FULL_BAG;
                for (int i = 0; i < QDEPTH; i++) begin
                    q[i] <= EMPTY;
                end
                cnt        <= 3'd0;
                hold_valid <= 1'b0;
                hold_idx   <= EMPTY;
                hold_used  <= 1'b0;
                busy       <= 1'b0;
                pend_hold  <= 1'b0;
                pend_swap  <= 1'b0;
            end else begin
                q   <= q_n;
                cnt <= cnt_n;
                if (draw_ok) begin
                    bag_mask <= mask_n;
                end

                case (state)
                    S_IDLE: begin
                        if (spawn_req) begin
                            // spawn_req wins over a simultaneous hold_req
                            state       <= S_WAIT;
                            busy        <= 1'b1;
                            pend_hold   <= 1'b0;
                            pend_swap   <= 1'b0;
                            hold_reject <= hold_req;
                        end else if (hold_req) begin
                            if (hold_used) begin
                                hold_reject <= 1'b1;
                            end else begin
                                state       <= S_WAIT;
                                busy        <= 1'b1;
                                hold_used   <= 1'b1;
                                pend_hold   <= 1'b1;
                                pend_swap   <= hold_valid;
                                pend_active <= active_idx;
                            end
                        end
                    end

                    S_WAIT: begin
                        hold_reject <= hold_req;
                        if (serve) begin
                            state       <= S_ISSUE;
                            busy        <= 1'b0;
                            spawn_valid <= 1'b1;
                            if (pend_swap) begin
                                spawn_idx       <= hold_idx;
                                spawn_from_hold <= 1'b1;
                                hold_idx        <= pend_active;
                            end else begin
                                spawn_idx       <= q[0];
                                spawn_from_hold <= 1'b0;
                                if (pend_hold) begin
                                    // first hold of the game: park the active piece
                                    hold_idx   <= pend_active;
                                    hold_valid <= 1'b1;
                                end else begin
                                    hold_used <= 1'b0;
                                end
                            end
                        end
                    end

                    S_ISSUE: begin
                        hold_reject <= hold_req;
                        state       <= S_IDLE;
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
